// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: state encoding, default phase
// lengths, output bundle and the state-to-output decode.
//   state_t        : sequencer states (HOLD, RST, INIT, SETTLE, RUN)
//   seq_out_t      : registered output bundle
//   decode_outputs : output values for a given state
package reset_seq_pkg;

   localparam int unsigned DEF_RESET_CYCLES  = 16;
   localparam int unsigned DEF_INIT_CYCLES   = 10;
   localparam int unsigned DEF_SETTLE_CYCLES = 4;
   localparam int unsigned DEF_CNT_W         = 16;
   localparam int unsigned COUNT_W           = 8;

   typedef enum logic [2:0] {
      S_HOLD   = 3'd0,
      S_RST    = 3'd1,
      S_INIT   = 3'd2,
      S_SETTLE = 3'd3,
      S_RUN    = 3'd4
   } state_t;

   typedef struct packed {
      logic cpu_reset;
      logic bus_init;
      logic run_enable;
      logic busy;
   } seq_out_t;

   // Output decode; bus_init only ever appears together with cpu_reset.
   function automatic seq_out_t decode_outputs(input state_t s);
      seq_out_t o;
      o.cpu_reset  = 1'b1;
      o.bus_init   = 1'b0;
      o.run_enable = 1'b0;
      o.busy       = 1'b1;
      case (s)
         S_INIT:   o.bus_init = 1'b1;
         S_SETTLE: o.cpu_reset = 1'b0;
         S_RUN: begin
            o.cpu_reset  = 1'b0;
            o.run_enable = 1'b1;
            o.busy       = 1'b0;
         end
         default: ;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Request/status bundle between the panel debouncer side and the reset
// sequencer.
//   req_in      : reset request level (asynchronous to clk)
//   cpu_reset   : CPU state reset
//   bus_init    : Unibus INIT pulse
//   run_enable  : CPU allowed to fetch
//   busy        : sequence in progress
//   reset_count : saturating count of sequences started
// master = the sequencer, slave = the request source / status observer.
interface reset_sequencer_if;
   import reset_seq_pkg::*;

   logic               req_in;
   logic               cpu_reset;
   logic               bus_init;
   logic               run_enable;
   logic               busy;
   logic [COUNT_W-1:0] reset_count;

   modport master (
      input  req_in,
      output cpu_reset, bus_init, run_enable, busy, reset_count
   );

   modport slave (
      output req_in,
      input  cpu_reset, bus_init, run_enable, busy, reset_count
   );

endinterface

// File: rtl/sync2.sv
// Generic two-flop level synchroniser with synchronous clear, for
// front-panel inputs generated in another clock domain.
//   clk : destination clock
//   clr : synchronous active-high clear of both stages
//   d   : asynchronous input level(s)
//   q   : synchronised level(s), two clk of latency
module sync2 #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // First stage may go metastable; second stage gives it a cycle to settle.
   always_ff @(posedge clk) begin
      if (clr) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/reset_sequencer.sv
// Ordered system reset for the PDP-11 core and Unibus: CPU reset hold, bus
// INIT pulse, settle gap, then run enable. Each phase has a fixed minimum
// length measured from release of the (synchronised) request.
//   clk   : system clock
//   reset : synchronous active-high reset (counts as a sequence start)
//   sif   : request input and registered sequencer outputs
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int unsigned RESET_CYCLES  = DEF_RESET_CYCLES,
   parameter int unsigned INIT_CYCLES   = DEF_INIT_CYCLES,
   parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int unsigned CNT_W         = DEF_CNT_W
) (
   input  logic               clk,
   input  logic               reset,
   reset_sequencer_if.master  sif
);

   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] INIT_LAST   = CNT_W'(INIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

   logic               req_s;
   state_t             state;
   state_t             nxt_c;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nxt_c;
   logic [COUNT_W-1:0] count;
   seq_out_t           outs;

   sync2 #(.WIDTH(1)) u_sync (
      .clk (clk),
      .clr (reset),
      .d   (sif.req_in),
      .q   (req_s)
   );

   // Transition rule: a live request always wins and parks the FSM in HOLD.
   function automatic state_t next_state(input state_t s, input logic req,
                                         input logic [CNT_W-1:0] c);
      state_t n;
      n = s;
      if (req) begin
         n = S_HOLD;
      end else begin
         case (s)
            S_HOLD:   n = S_RST;
            S_RST:    if (c == RST_LAST) n = S_INIT;
            S_INIT:   if (c == INIT_LAST) n = (SETTLE_CYCLES == 0) ? S_RUN : S_SETTLE;
            S_SETTLE: if (c == SETTLE_LAST) n = S_RUN;
            S_RUN:    n = S_RUN;
            default:  n = S_HOLD;
         endcase
      end
      return n;
   endfunction

   assign nxt_c = next_state(state, req_s, cnt);

   // Phase counter restarts on every state change and idles at 0 in HOLD/RUN.
   assign cnt_nxt_c = (nxt_c != state || nxt_c == S_HOLD || nxt_c == S_RUN)
                      ? '0 : cnt + CNT_W'(1);

   // FSM, phase counter, event counter and outputs decoded from next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_HOLD;
         cnt   <= '0;
         count <= COUNT_W'(1);
         outs  <= decode_outputs(S_HOLD);
      end else begin
         state <= nxt_c;
         cnt   <= cnt_nxt_c;
         outs  <= decode_outputs(nxt_c);
         // Entering HOLD from anywhere else is a new sequence start.
         if (req_s && state != S_HOLD && count != COUNT_MAX) begin
            count <= count + COUNT_W'(1);
         end
      end
   end

   assign sif.cpu_reset   = outs.cpu_reset;
   assign sif.bus_init    = outs.bus_init;
   assign sif.run_enable  = outs.run_enable;
   assign sif.busy        = outs.busy;
   assign sif.reset_count = count;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a default-parameter instance and a minimal
// 1/1/0 instance share clock, reset and request. A timeline model (cycles
// since release) predicts both every cycle; tables and hand sequences pin
// down the power-up, press, restart and saturation cases.
module tb_reset_sequencer;
   import reset_seq_pkg::*;

   localparam int unsigned R1 = 1;
   localparam int unsigned I1 = 1;
   localparam int unsigned S1 = 0;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic req = 1'b0;
   int   n_pass = 0;
   int   n_total = 0;
   int   cyc = 0;

   always #5 clk = ~clk;

   reset_sequencer_if if0();
   reset_sequencer_if if1();
   assign if0.req_in = req;
   assign if1.req_in = req;

   reset_sequencer u0 (.clk(clk), .reset(reset), .sif(if0));
   reset_sequencer #(
      .RESET_CYCLES(R1), .INIT_CYCLES(I1), .SETTLE_CYCLES(S1), .CNT_W(16)
   ) u1 (.clk(clk), .reset(reset), .sif(if1));

   // ---------------- reference model ----------------
   int   m_r [2];
   int   m_i [2];
   int   m_st[2];
   logic m_s1, m_s, m_hold;
   int   m_t, m_cnt;

   task automatic model_edge();
      if (reset) begin
         m_s1 = 1'b0; m_s = 1'b0; m_hold = 1'b1; m_t = 0; m_cnt = 1;
      end else begin
         if (m_s) begin
            if (!m_hold) begin
               m_hold = 1'b1;
               if (m_cnt < 255) m_cnt++;
            end
         end else if (m_hold) begin
            m_hold = 1'b0;
            m_t = 0;
         end else if (m_t < 1000000) begin
            m_t++;
         end
         m_s  = m_s1;
         m_s1 = req;
      end
   endtask

   function automatic logic [11:0] model_out(input int d);
      logic cpu, ini, run;
      int a;
      if (m_hold) return {4'b1001, 8'(m_cnt)};
      a   = m_r[d] + m_i[d];
      cpu = (m_t < a);
      ini = (m_t >= m_r[d]) && (m_t < a);
      run = (m_t >= a + m_st[d]);
      return {cpu, ini, run, ~run, 8'(m_cnt)};
   endfunction

   function automatic logic [11:0] dut_out(input int d);
      if (d == 0)
         return {if0.cpu_reset, if0.bus_init, if0.run_enable, if0.busy, if0.reset_count};
      return {if1.cpu_reset, if1.bus_init, if1.run_enable, if1.busy, if1.reset_count};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
   endtask

   // One clock: advance model, then compare both instances and invariants.
   task automatic step();
      logic [11:0] a;
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
      for (int d = 0; d < 2; d++) begin
         a = dut_out(d);
         check(d == 0 ? "model_d0" : "model_d1", 32'(a), 32'(model_out(d)));
         check("inv_run_excl", 32'(a[9] & (a[11] | a[10])), 32'd0);
         check("inv_init_cpu", 32'(a[10] & ~a[11]), 32'd0);
      end
   endtask

   task automatic run_to_run(input int maxc, output int n, output int n_init);
      n = 0; n_init = 0;
      while (n < maxc) begin
         step();
         n++;
         if (if0.bus_init) n_init++;
         if (if0.run_enable) break;
      end
   endtask

   typedef struct {
      int          dut;
      int          first;
      int          last;
      logic        req;
      logic [11:0] exp;
   } vec_t;

   vec_t tbl[$];

   initial begin
      int n, ni, k;
      logic saw_init, all_cpu;

      m_r[0] = DEF_RESET_CYCLES; m_i[0] = DEF_INIT_CYCLES; m_st[0] = DEF_SETTLE_CYCLES;
      m_r[1] = R1;               m_i[1] = I1;              m_st[1] = S1;
      m_s1 = 1'b0; m_s = 1'b0; m_hold = 1'b1; m_t = 0; m_cnt = 1;

      // Power-up timeline, cycle 0 = first clock after reset falls.
      tbl.push_back('{0, 0, 15, 1'b0, {4'b1001, 8'd1}});
      tbl.push_back('{0, 16, 25, 1'b0, {4'b1101, 8'd1}});
      tbl.push_back('{0, 26, 29, 1'b0, {4'b0001, 8'd1}});
      tbl.push_back('{0, 30, 33, 1'b0, {4'b0010, 8'd1}});
      tbl.push_back('{1, 0, 0, 1'b0, {4'b1001, 8'd1}});
      tbl.push_back('{1, 1, 1, 1'b0, {4'b1101, 8'd1}});
      tbl.push_back('{1, 2, 33, 1'b0, {4'b0010, 8'd1}});

      reset = 1'b1; req = 1'b0;
      for (int i = 0; i < 3; i++) step();
      check("rst_d0", 32'(dut_out(0)), 32'({4'b1001, 8'd1}));
      check("rst_d1", 32'(dut_out(1)), 32'({4'b1001, 8'd1}));
      reset = 1'b0;

      for (int c = 0; c < 34; c++) begin
         req = 1'b0;
         step();
         foreach (tbl[j]) begin
            if (c >= tbl[j].first && c <= tbl[j].last)
               check(tbl[j].dut == 0 ? "pwr_tbl_d0" : "pwr_tbl_d1",
                     32'(dut_out(tbl[j].dut)), 32'(tbl[j].exp));
         end
      end

      // Short press: one-cycle request while running.
      req = 1'b1;
      n = 0;
      while (n < 10) begin
         step();
         n++;
         req = 1'b0;
         if (!if0.run_enable) break;
      end
      check("short_fall_lat", 32'(n), 32'd3);
      run_to_run(60, n, ni);
      check("short_run_lat", 32'(n), 32'd31);
      check("short_init_len", 32'(ni), 32'd10);
      check("short_count", 32'(if0.reset_count), 32'd2);

      // Long press: 500 cycles held.
      req = 1'b1;
      saw_init = 1'b0; all_cpu = 1'b1;
      for (int i = 0; i < 500; i++) begin
         step();
         if (i >= 2) begin
            saw_init |= if0.bus_init;
            all_cpu  &= if0.cpu_reset;
         end
      end
      check("long_no_init", 32'(saw_init), 32'd0);
      check("long_cpu_held", 32'(all_cpu), 32'd1);
      check("long_count", 32'(if0.reset_count), 32'd3);
      req = 1'b0;
      run_to_run(60, n, ni);
      check("long_run_lat", 32'(n), 32'd33);
      check("long_init_len", 32'(ni), 32'd10);
      check("long_count_once", 32'(if0.reset_count), 32'd3);

      // Restart mid-INIT.
      req = 1'b1;
      step();
      req = 1'b0;
      k = 0;
      while (!if0.bus_init && k < 60) begin
         step();
         k++;
      end
      check("mid_init_seen", 32'(if0.bus_init), 32'd1);
      for (int i = 0; i < 5; i++) step();
      req = 1'b1;
      step();
      req = 1'b0;
      step();
      step();
      check("mid_hold", 32'(dut_out(0)), 32'({4'b1001, 8'd5}));
      run_to_run(60, n, ni);
      check("mid_full_init", 32'(ni), 32'd10);
      check("mid_run", 32'(if0.run_enable), 32'd1);

      // Saturation of the event counter.
      for (int i = 0; i < 300; i++) begin
         req = 1'b1;
         step();
         req = 1'b0;
         for (int j = 0; j < 3; j++) step();
      end
      check("sat_d0", 32'(if0.reset_count), 32'd255);
      check("sat_d1", 32'(if1.reset_count), 32'd255);
      for (int i = 0; i < 20; i++) begin
         req = 1'b1;
         step();
         req = 1'b0;
         for (int j = 0; j < 3; j++) step();
      end
      check("sat_stay", 32'(if0.reset_count), 32'd255);

      // Reset mid-run returns count to 1.
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      check("rerst_count", 32'(if0.reset_count), 32'd1);

      // Random request traffic with varying toggle density and rare resets.
      k = 5;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) begin
            case ($urandom_range(0, 2))
               0: k = 1;
               1: k = 5;
               default: k = 30;
            endcase
         end
         if ($urandom_range(0, 99) < k) req = ~req;
         reset = ($urandom_range(0, 799) == 0);
         step();
      end
      reset = 1'b0;
      req = 1'b0;
      for (int i = 0; i < 40; i++) step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
